// File: rtl/nonce_search_ctrl_if.sv
// Bundle of host-side search controls and hash-unit handshake for nonce_search_ctrl.
// master = environment (host + hash unit), slave = the controller.
interface nonce_search_ctrl_if #(
    parameter int NONCE_W = 32,
    parameter int HASH_W  = 24
);
    logic               start;
    logic               abort;
    logic [95:0]        data_entry_12;
    logic [NONCE_W-1:0] nonce_init;
    logic [NONCE_W-1:0] nonce_limit;
    logic [7:0]         data_target;
    logic               hash_start;
    logic [95:0]        hash_block;
    logic [NONCE_W-1:0] hash_nonce;
    logic               hash_done;
    logic [HASH_W-1:0]  hash_value;
    logic               busy;
    logic               found;
    logic               exhausted;
    logic [NONCE_W-1:0] result_nonce;
    logic [HASH_W-1:0]  result_hash;
    logic [31:0]        tries;

    modport master (
        output start, abort, data_entry_12, nonce_init, nonce_limit, data_target,
               hash_done, hash_value,
        input  hash_start, hash_block, hash_nonce, busy, found, exhausted,
               result_nonce, result_hash, tries
    );

    modport slave (
        input  start, abort, data_entry_12, nonce_init, nonce_limit, data_target,
               hash_done, hash_value,
        output hash_start, hash_block, hash_nonce, busy, found, exhausted,
               result_nonce, result_hash, tries
    );
endinterface

// File: rtl/nonce_search_ctrl.sv
// Sequences the hash unit over a nonce range and reports the first nonce whose
// top two hash bytes are both strictly below the target, or exhaustion.
module nonce_search_ctrl #(
    parameter int NONCE_W = 32,
    parameter int HASH_W  = 24
) (
    input  logic             clk,
    input  logic             reset,
    nonce_search_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_CHECK  = 2'd3;

    logic [1:0]         r_state;
    logic [95:0]        r_block;
    logic [7:0]         r_target;
    logic [NONCE_W-1:0] r_limit;
    logic [NONCE_W-1:0] r_nonce;
    logic [HASH_W-1:0]  r_hash;
    logic               r_found;
    logic               r_exhausted;
    logic [NONCE_W-1:0] r_res_nonce;
    logic [HASH_W-1:0]  r_res_hash;
    logic [31:0]        r_tries;

    logic        w_pass;
    logic        w_last;
    logic [31:0] w_tries_inc;

    assign w_pass      = (r_hash[HASH_W-1 -: 8] < r_target) && (r_hash[HASH_W-9 -: 8] < r_target);
    assign w_last      = (r_nonce == r_limit);
    assign w_tries_inc = (r_tries == 32'hFFFF_FFFF) ? r_tries : r_tries + 32'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_block     <= '0;
            r_target    <= '0;
            r_limit     <= '0;
            r_nonce     <= '0;
            r_hash      <= '0;
            r_found     <= 1'b0;
            r_exhausted <= 1'b0;
            r_res_nonce <= '0;
            r_res_hash  <= '0;
            r_tries     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_block     <= bus.data_entry_12;
                        r_target    <= bus.data_target;
                        r_limit     <= bus.nonce_limit;
                        r_nonce     <= bus.nonce_init;
                        r_found     <= 1'b0;
                        r_exhausted <= 1'b0;
                        r_tries     <= '0;
                        r_state     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    r_state <= bus.abort ? S_IDLE : S_WAIT;
                end
                S_WAIT: begin
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                    end else if (bus.hash_done) begin
                        r_hash  <= bus.hash_value;
                        r_state <= S_CHECK;
                    end
                end
                default: begin
                    // abort wins over the check result and leaves tries untouched
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_tries <= w_tries_inc;
                        if (w_pass) begin
                            r_found     <= 1'b1;
                            r_res_nonce <= r_nonce;
                            r_res_hash  <= r_hash;
                            r_state     <= S_IDLE;
                        end else if (w_last) begin
                            r_exhausted <= 1'b1;
                            r_state     <= S_IDLE;
                        end else begin
                            r_nonce <= r_nonce + 1'b1;
                            r_state <= S_LAUNCH;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.hash_start   = (r_state == S_LAUNCH);
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.hash_block   = r_block;
    assign bus.hash_nonce   = r_nonce;
    assign bus.found        = r_found;
    assign bus.exhausted    = r_exhausted;
    assign bus.result_nonce = r_res_nonce;
    assign bus.result_hash  = r_res_hash;
    assign bus.tries        = r_tries;
endmodule

// File: tb/tb_nonce_search_ctrl.sv
// Directed bench for nonce_search_ctrl with a small hash-unit responder model.
module tb_nonce_search_ctrl;
    logic clk;
    logic reset;

    nonce_search_ctrl_if #(.NONCE_W(32), .HASH_W(24)) bus ();

    nonce_search_ctrl #(.NONCE_W(32), .HASH_W(24)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          ntests = 0;
    int          nfail  = 0;
    int          mode   = 0;
    int          resp_cnt   = 0;
    int          resp_limit = 1000;
    logic        pend  = 1'b0;
    logic        drove = 1'b0;
    logic [31:0] launches[$];

    localparam logic [95:0] BLK = 96'h39_0c_7f_e2_5a_11_b4_68_d3_90_4e_24;

    function automatic logic [23:0] model_hash(input logic [31:0] n);
        case (mode)
            0:       return 24'h123456;
            1:       return (n == 32'h103) ? 24'h0A0BFF : 24'hFFFFFF;
            default: return 24'hFFFFFF;
        endcase
    endfunction

    // Hash-unit model: done arrives in the cycle after the launch pulse.
    always @(negedge clk) begin
        if (drove) begin
            bus.hash_done = 1'b0;
            drove = 1'b0;
        end
        if (pend) begin
            bus.hash_done  = 1'b1;
            bus.hash_value = model_hash(bus.hash_nonce);
            drove = 1'b1;
            pend  = 1'b0;
        end
        if (reset && bus.hash_start) begin
            launches.push_back(bus.hash_nonce);
            if (resp_cnt < resp_limit) begin
                pend = 1'b1;
                resp_cnt++;
            end
        end
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [95:0] blk, input logic [31:0] init, input logic [31:0] lim,
                          input logic [7:0] tgt);
        launches.delete();
        @(negedge clk);
        bus.data_entry_12 = blk;
        bus.nonce_init    = init;
        bus.nonce_limit   = lim;
        bus.data_target   = tgt;
        bus.start         = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("launch_pulse", {95'd0, bus.hash_start}, 96'd1);
        chk("launch_nonce", {64'd0, bus.hash_nonce}, {64'd0, init});
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (bus.busy && cyc < 2000) begin
            cyc++;
            @(negedge clk);
        end
        if (bus.busy) chk("idle_timeout", {95'd0, bus.busy}, 96'd0);
    endtask

    task automatic single_hit(input string pfx);
        int cyc;
        mode = 0; resp_cnt = 0; resp_limit = 1000;
        launch(BLK, 32'hfded873c, 32'hfded873c, 8'hff);
        chk({pfx, "_block"}, bus.hash_block, BLK);
        wait_idle(cyc);
        chk({pfx, "_busy_cycles"}, 96'(cyc), 96'd3);
        chk({pfx, "_launches"}, 96'(launches.size()), 96'd1);
        chk({pfx, "_found"}, {95'd0, bus.found}, 96'd1);
        chk({pfx, "_exhausted"}, {95'd0, bus.exhausted}, 96'd0);
        chk({pfx, "_res_nonce"}, {64'd0, bus.result_nonce}, {64'd0, 32'hfded873c});
        chk({pfx, "_res_hash"}, {72'd0, bus.result_hash}, {72'd0, 24'h123456});
        chk({pfx, "_tries"}, {64'd0, bus.tries}, 96'd1);
    endtask

    initial begin
        int cyc;
        reset = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.data_entry_12 = '0;
        bus.nonce_init = '0; bus.nonce_limit = '0; bus.data_target = '0;
        bus.hash_done = 1'b0; bus.hash_value = '0;

        // Power-up reset
        repeat (2) @(negedge clk);
        chk("rst_busy", {95'd0, bus.busy}, 96'd0);
        chk("rst_start", {95'd0, bus.hash_start}, 96'd0);
        chk("rst_flags", {94'd0, bus.found, bus.exhausted}, 96'd0);
        chk("rst_regs", {bus.hash_nonce, bus.result_nonce, bus.tries}, 96'd0);
        chk("rst_block", bus.hash_block, 96'd0);
        chk("rst_res_hash", {72'd0, bus.result_hash}, 96'd0);
        reset = 1'b1;
        @(negedge clk);
        bus.hash_done = 1'b1; bus.hash_value = 24'h000000;
        @(negedge clk);
        bus.hash_done = 1'b0;
        @(negedge clk);
        chk("idle_done_busy", {95'd0, bus.busy}, 96'd0);
        chk("idle_done_tries", {64'd0, bus.tries}, 96'd0);
        chk("idle_done_found", {95'd0, bus.found}, 96'd0);

        single_hit("hit");

        // Search over a range, pass at 0x103
        mode = 1; resp_cnt = 0;
        launch(BLK, 32'h100, 32'h1FF, 8'h10);
        wait_idle(cyc);
        chk("srch_launches", 96'(launches.size()), 96'd4);
        for (int i = 0; i < 4 && i < launches.size(); i++)
            chk("srch_nonce", {64'd0, launches[i]}, 96'(32'h100 + i));
        chk("srch_found", {95'd0, bus.found}, 96'd1);
        chk("srch_res_nonce", {64'd0, bus.result_nonce}, 96'h103);
        chk("srch_res_hash", {72'd0, bus.result_hash}, {72'd0, 24'h0A0BFF});
        chk("srch_tries", {64'd0, bus.tries}, 96'd4);
        chk("srch_busy_cycles", 96'(cyc), 96'd12);

        // Wrap through zero and exhaust
        mode = 2; resp_cnt = 0;
        launch(BLK, 32'hFFFFFFFE, 32'h00000001, 8'hff);
        wait_idle(cyc);
        chk("wrap_launches", 96'(launches.size()), 96'd4);
        if (launches.size() == 4) begin
            chk("wrap_n0", {64'd0, launches[0]}, {64'd0, 32'hFFFFFFFE});
            chk("wrap_n1", {64'd0, launches[1]}, {64'd0, 32'hFFFFFFFF});
            chk("wrap_n2", {64'd0, launches[2]}, 96'd0);
            chk("wrap_n3", {64'd0, launches[3]}, 96'd1);
        end
        chk("wrap_exhausted", {95'd0, bus.exhausted}, 96'd1);
        chk("wrap_found", {95'd0, bus.found}, 96'd0);
        chk("wrap_tries", {64'd0, bus.tries}, 96'd4);

        // Target zero never passes: init==limit gives one try then exhaustion
        mode = 0; resp_cnt = 0;
        launch(BLK, 32'h5, 32'h5, 8'h00);
        wait_idle(cyc);
        chk("tgt0_exhausted", {94'd0, bus.found, bus.exhausted}, 96'd1);
        chk("tgt0_tries", {64'd0, bus.tries}, 96'd1);

        // Abort during WAIT of the second try
        mode = 2; resp_cnt = 0; resp_limit = 1;
        launch(BLK, 32'h10, 32'h20, 8'h10);
        cyc = 0;
        while (launches.size() < 2 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        chk("abort_second_launch", 96'(launches.size()), 96'd2);
        @(negedge clk);
        chk("abort_busy_before", {95'd0, bus.busy}, 96'd1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_busy", {95'd0, bus.busy}, 96'd0);
        chk("abort_flags", {94'd0, bus.found, bus.exhausted}, 96'd0);
        chk("abort_tries", {64'd0, bus.tries}, 96'd1);
        bus.hash_done = 1'b1; bus.hash_value = 24'h000000;
        @(negedge clk);
        bus.hash_done = 1'b0;
        @(negedge clk);
        chk("late_done_busy", {95'd0, bus.busy}, 96'd0);
        chk("late_done_tries", {64'd0, bus.tries}, 96'd1);
        chk("late_done_found", {95'd0, bus.found}, 96'd0);

        // start while busy is ignored
        resp_cnt = 0; resp_limit = 0;
        launch(BLK, 32'h50, 32'h60, 8'h10);
        bus.nonce_init = 32'h77;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_start_launches", 96'(launches.size()), 96'd1);
        chk("busy_start_nonce", {64'd0, bus.hash_nonce}, 96'h50);
        chk("busy_start_busy", {95'd0, bus.busy}, 96'd1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("busy_start_abort", {95'd0, bus.busy}, 96'd0);

        // Asynchronous reset in the middle of WAIT
        mode = 0; resp_cnt = 0; resp_limit = 0;
        launch(BLK, 32'hfded873c, 32'hfded873c, 8'hff);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_busy", {94'd0, bus.busy, bus.hash_start}, 96'd0);
        chk("mid_rst_block", bus.hash_block, 96'd0);
        chk("mid_rst_regs", {bus.hash_nonce, bus.result_nonce, bus.tries}, 96'd0);
        chk("mid_rst_flags", {94'd0, bus.found, bus.exhausted}, 96'd0);
        @(negedge clk);
        reset = 1'b1;
        single_hit("rehit");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
